// File: rtl/aoc_d5_pkg.sv
// Shared types and defaults for the page-ordering pipeline's update scorer.
package aoc_d5_pkg;

  localparam int DEFAULT_PAGE_W    = 8;
  localparam int DEFAULT_MAX_PAGES = 32;

  typedef logic [DEFAULT_PAGE_W-1:0] page_t;

  typedef enum logic {
    COLLECT = 1'b0,
    RESOLVE = 1'b1
  } scorer_state_e;

  typedef logic [$clog2(DEFAULT_MAX_PAGES):0] count_t;

endpackage

// File: rtl/update_scorer_if.sv
// Page stream in / line score out bundle for update_scorer.
// UPDATE_SCORER_STATS_EN adds the good/bad line counters.
interface update_scorer_if #(
  parameter int PAGE_W = 8,
  parameter int SUM_W  = 32
);
  logic              en;
  logic [PAGE_W-1:0] data;
  logic              newline;
  logic              any_broken;
  logic              ready;
  logic              result_valid;
  logic              line_ok;
  logic [PAGE_W-1:0] middle_page;
  logic [SUM_W-1:0]  sum;
  logic              overflow;
  logic              sum_ovf;
  logic              protocol_err;
`ifdef UPDATE_SCORER_STATS_EN
  logic [SUM_W-1:0]  good_lines;
  logic [SUM_W-1:0]  bad_lines;

  modport master (
    output en, data, newline, any_broken,
    input  ready, result_valid, line_ok, middle_page, sum,
    input  overflow, sum_ovf, protocol_err, good_lines, bad_lines
  );
  modport slave (
    input  en, data, newline, any_broken,
    output ready, result_valid, line_ok, middle_page, sum,
    output overflow, sum_ovf, protocol_err, good_lines, bad_lines
  );
`else
  modport master (
    output en, data, newline, any_broken,
    input  ready, result_valid, line_ok, middle_page, sum,
    input  overflow, sum_ovf, protocol_err
  );
  modport slave (
    input  en, data, newline, any_broken,
    output ready, result_valid, line_ok, middle_page, sum,
    output overflow, sum_ovf, protocol_err
  );
`endif
endinterface

// File: rtl/page_line_buf.sv
// One-line page buffer: single write port, registered read port, storage not reset.
module page_line_buf #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/update_scorer.sv
// Buffers each update line, scores it at end of line and sums middle pages of valid lines.
// Define UPDATE_SCORER_STATS_EN to add good_lines / bad_lines counters.
module update_scorer #(
  parameter int PAGE_W    = aoc_d5_pkg::DEFAULT_PAGE_W,
  parameter int MAX_PAGES = aoc_d5_pkg::DEFAULT_MAX_PAGES,
  parameter int SUM_W     = 32
) (
  input  logic           clk,
  input  logic           rst,
  update_scorer_if.slave bus
);
  import aoc_d5_pkg::*;

  localparam int ADDR_W = $clog2(MAX_PAGES);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int SUM_W1 = SUM_W + 1;

  scorer_state_e     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              line_broken_q, line_broken_d;
  logic              line_ovf_q, line_ovf_d;
  logic              line_ok_q, line_ok_d;
  logic [PAGE_W-1:0] middle_q, middle_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic              overflow_q, overflow_d;
  logic              sum_ovf_q, sum_ovf_d;
  logic              protocol_err_q, protocol_err_d;

  logic              resolving;
  logic              buf_we;
  logic              buf_re;
  logic [PAGE_W-1:0] buf_rdata;
  logic [SUM_W:0]    sum_ext;

  assign resolving = (state_q == RESOLVE);
  // Count saturates at MAX_PAGES, so the top count bit doubles as "buffer full".
  assign buf_we    = !resolving && bus.en && !bus.newline && !count_q[ADDR_W];
  assign buf_re    = !resolving && bus.en && bus.newline && (count_q != '0);
  assign sum_ext   = {1'b0, sum_q} + SUM_W1'(buf_rdata);

  page_line_buf #(
    .DEPTH (MAX_PAGES),
    .WIDTH (PAGE_W)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (bus.data),
    .re    (buf_re),
    .raddr (count_q[CNT_W-1:1]),
    .rdata (buf_rdata)
  );

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    line_broken_d  = line_broken_q;
    line_ovf_d     = line_ovf_q;
    line_ok_d      = line_ok_q;
    middle_d       = middle_q;
    sum_d          = sum_q;
    overflow_d     = overflow_q;
    sum_ovf_d      = sum_ovf_q;
    protocol_err_d = protocol_err_q;
    case (state_q)
      COLLECT: begin
        if (bus.en && !bus.newline) begin
          if (count_q[ADDR_W]) begin
            line_ovf_d = 1'b1;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
          line_broken_d = line_broken_q | bus.any_broken;
        end else if (bus.en && bus.newline && (count_q != '0)) begin
          // Verdict is known now; only the middle page waits for the buffer read.
          line_ok_d = !line_broken_q && !line_ovf_q;
          state_d   = RESOLVE;
        end
      end
      RESOLVE: begin
        if (bus.en) begin
          protocol_err_d = 1'b1;
        end
        middle_d = buf_rdata;
        if (line_ok_q) begin
          sum_d     = sum_ext[SUM_W-1:0];
          sum_ovf_d = sum_ovf_q | sum_ext[SUM_W];
        end
        count_d       = '0;
        line_broken_d = 1'b0;
        line_ovf_d    = 1'b0;
        state_d       = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= COLLECT;
      count_q        <= '0;
      line_broken_q  <= 1'b0;
      line_ovf_q     <= 1'b0;
      line_ok_q      <= 1'b0;
      middle_q       <= '0;
      sum_q          <= '0;
      overflow_q     <= 1'b0;
      sum_ovf_q      <= 1'b0;
      protocol_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      line_broken_q  <= line_broken_d;
      line_ovf_q     <= line_ovf_d;
      line_ok_q      <= line_ok_d;
      middle_q       <= middle_d;
      sum_q          <= sum_d;
      overflow_q     <= overflow_d;
      sum_ovf_q      <= sum_ovf_d;
      protocol_err_q <= protocol_err_d;
    end
  end

  // During the pulse the read data is live, so the new total is shown in that same cycle.
  assign bus.ready        = !resolving;
  assign bus.result_valid = resolving;
  assign bus.line_ok      = line_ok_q;
  assign bus.middle_page  = resolving ? buf_rdata : middle_q;
  assign bus.sum          = (resolving && line_ok_q) ? sum_ext[SUM_W-1:0] : sum_q;
  assign bus.sum_ovf      = sum_ovf_q | (resolving && line_ok_q && sum_ext[SUM_W]);
  assign bus.overflow     = overflow_q;
  assign bus.protocol_err = protocol_err_q;

`ifdef UPDATE_SCORER_STATS_EN
  logic [SUM_W-1:0] good_q, good_d;
  logic [SUM_W-1:0] bad_q, bad_d;

  always_comb begin
    good_d = good_q;
    bad_d  = bad_q;
    if (resolving) begin
      if (line_ok_q) begin
        good_d = good_q + 1'b1;
      end else begin
        bad_d = bad_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign bus.good_lines = good_q;
  assign bus.bad_lines  = bad_q;
`endif

endmodule

// File: tb/tb_update_scorer.sv
// Scoreboard bench for update_scorer: stimulus pushes expected line results, a monitor checks pulses.
module tb_update_scorer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  update_scorer_if #(.PAGE_W(8), .SUM_W(32)) bus ();

  update_scorer #(.PAGE_W(8), .MAX_PAGES(32), .SUM_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit      ok;
    int      mid;
    longint  sum;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input bit ok, input int mid, input longint sum);
    exp_t e;
    e.ok  = ok;
    e.mid = mid;
    e.sum = sum;
    exp_q.push_back(e);
  endtask

  task automatic page(input int d, input bit brk);
    @(negedge clk);
    bus.en         = 1'b1;
    bus.newline    = 1'b0;
    bus.data       = 8'(d);
    bus.any_broken = brk;
  endtask

  task automatic nl();
    @(negedge clk);
    bus.en         = 1'b1;
    bus.newline    = 1'b1;
    bus.data       = 8'hEE;
    bus.any_broken = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.en         = 1'b0;
    bus.newline    = 1'b0;
    bus.any_broken = 1'b0;
  endtask

  // Monitor: one pulse per non-empty line, in order.
  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got middle %0d sum %0d, expected no pulse",
                 bus.middle_page, bus.sum);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("line_ok", longint'(bus.line_ok), longint'(e.ok));
        chk("middle_page", longint'(bus.middle_page), longint'(e.mid));
        chk("sum", longint'(bus.sum), e.sum);
        $display("line: ok=%0d middle=%0d sum=%0d", bus.line_ok, bus.middle_page, bus.sum);
      end
    end
  end

  initial begin
    int line1[5] = '{75, 47, 61, 53, 29};
    int line2[5] = '{97, 61, 53, 29, 13};
    int line3[5] = '{75, 97, 47, 61, 53};
    bus.en = 1'b0;
    bus.newline = 1'b0;
    bus.data = '0;
    bus.any_broken = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(bus.ready), 1);
    chk("rst_valid", longint'(bus.result_valid), 0);
    chk("rst_sum", longint'(bus.sum), 0);
    chk("rst_flags", longint'({bus.overflow, bus.sum_ovf, bus.protocol_err, bus.line_ok}), 0);
    chk("rst_middle", longint'(bus.middle_page), 0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) page(line1[i], 1'b0);
    nl(); push(1'b1, 61, 61);
    idle();
    for (int i = 0; i < 5; i++) page(line2[i], 1'b0);
    nl(); push(1'b1, 53, 114);
    idle();
    for (int i = 0; i < 5; i++) page(line3[i], (i == 1));
    nl(); push(1'b0, 47, 114);
    idle();
    idle();
    chk("hold_middle", longint'(bus.middle_page), 47);
    chk("hold_line_ok", longint'(bus.line_ok), 0);
    chk("hold_sum", longint'(bus.sum), 114);
`ifdef UPDATE_SCORER_STATS_EN
    chk("good_lines", longint'(bus.good_lines), 2);
    chk("bad_lines", longint'(bus.bad_lines), 1);
`endif

    chk("overflow_before", longint'(bus.overflow), 0);
    for (int i = 0; i < 33; i++) page(1, 1'b0);
    nl(); push(1'b0, 1, 114);
    idle();
    idle();
    chk("overflow_sticky", longint'(bus.overflow), 1);
    for (int i = 1; i <= 3; i++) page(i, 1'b0);
    nl(); push(1'b1, 2, 116);
    idle();

    nl();
    idle();
    chk("empty_no_pulse", longint'(bus.result_valid), 0);
    chk("empty_ready", longint'(bus.ready), 1);

    for (int i = 4; i <= 6; i++) page(i, 1'b0);
    nl(); push(1'b1, 5, 121);
    page(99, 1'b0);
    idle();
    chk("protocol_err", longint'(bus.protocol_err), 1);
    for (int i = 1; i <= 3; i++) page(i * 10, 1'b0);
    nl(); push(1'b1, 20, 141);
    idle();

    for (int i = 0; i < 3; i++) page(1, 1'b0);
    #2 rst = 1'b1;
    bus.en = 1'b0;
    #1;
    chk("arst_ready", longint'(bus.ready), 1);
    chk("arst_sum", longint'(bus.sum), 0);
    chk("arst_flags", longint'({bus.overflow, bus.protocol_err}), 0);
    @(negedge clk);
    rst = 1'b0;
    page(9, 1'b0);
    page(8, 1'b0);
    page(7, 1'b0);
    nl(); push(1'b1, 8, 8);
    idle();
    repeat (3) idle();
    chk("sum_ovf", longint'(bus.sum_ovf), 0);
    chk("pending_lines", longint'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
